control_fsm: RTL



---
 rtl/control_fsm_pkg.sv | 28 ++
 rtl/control_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the PikaRISC sequencer: FSM states and datapath mux selects.
// The datapath muxes import this package so both sides agree on the values.
package control_fsm_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_PUSH   = 3'd4;
    localparam logic [2:0] S_POP    = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [1:0] ADDR_SEL_PC    = 2'd0;
    localparam logic [1:0] ADDR_SEL_MEM   = 2'd1;
    localparam logic [1:0] ADDR_SEL_SP    = 2'd2;
    localparam logic [1:0] ADDR_SEL_SP_P1 = 2'd3;

    localparam logic [1:0] PC_SEL_INC = 2'd0;
    localparam logic [1:0] PC_SEL_TGT = 2'd1;
    localparam logic [1:0] PC_SEL_MEM = 2'd2;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    localparam logic WDATA_SEL_RT  = 1'b0;
    localparam logic WDATA_SEL_PC1 = 1'b1;

endpackage

// File: rtl/control_fsm.sv
// Multi-cycle sequencer for PikaRISC: schedules the shared memory port, drives
// datapath enables/selects, counts retired instructions and traps on faults.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 0,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_alu_op,
    input  logic             is_not_op,
    input  logic             is_cmp_op,
    input  logic             is_jmp_op,
    input  logic             is_ld_op,
    input  logic             is_str_op,
    input  logic             is_call_op,
    input  logic             is_ret_op,
    input  logic             cond_met,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       addr_sel,
    output logic             wdata_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             flags_we,
    output logic             sp_inc,
    output logic             sp_dec,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    logic [2:0]      state_nxt;
    logic            retire;
    logic            to_hit;
    logic [TO_W-1:0] to_cnt;
    logic            unused_ok;

    // NOT is an ordinary ALU op here; the flag is carried for the datapath only.
    assign unused_ok = is_not_op;

    // Fires on the last permitted waiting cycle so the next state is TRAP.
    assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = ADDR_SEL_PC;
        wdata_sel = WDATA_SEL_RT;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_INC;
        reg_we    = 1'b0;
        wb_sel    = WB_SEL_ALU;
        flags_we  = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        retire    = 1'b0;
        state_nxt = state;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    addr_sel = ADDR_SEL_PC;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        state_nxt = S_DECODE;
                    end else if (to_hit) begin
                        state_nxt = S_TRAP;
                    end
                end
                S_DECODE: begin
                    if (is_alu_op || is_jmp_op)     state_nxt = S_EXEC;
                    else if (is_ld_op || is_str_op) state_nxt = S_MEM;
                    else if (is_call_op)            state_nxt = S_PUSH;
                    else if (is_ret_op)             state_nxt = S_POP;
                    else                            state_nxt = S_TRAP;
                end
                S_EXEC: begin
                    pc_we = 1'b1;
                    if (is_alu_op) begin
                        flags_we = 1'b1;
                        reg_we   = !is_cmp_op;
                        pc_sel   = PC_SEL_INC;
                    end else begin
                        pc_sel = cond_met ? PC_SEL_TGT : PC_SEL_INC;
                    end
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    addr_sel  = ADDR_SEL_MEM;
                    mem_we    = is_str_op;
                    wdata_sel = WDATA_SEL_RT;
                    if (mem_ready) begin
                        reg_we    = is_ld_op;
                        wb_sel    = is_ld_op ? WB_SEL_MEM : WB_SEL_ALU;
                        pc_we     = 1'b1;
                        pc_sel    = PC_SEL_INC;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else if (to_hit) begin
                        state_nxt = S_TRAP;
                    end
                end
                S_PUSH: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    addr_sel  = ADDR_SEL_SP;
                    wdata_sel = WDATA_SEL_PC1;
                    if (mem_ready) begin
                        sp_dec    = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = PC_SEL_TGT;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else if (to_hit) begin
                        state_nxt = S_TRAP;
                    end
                end
                S_POP: begin
                    mem_req  = 1'b1;
                    addr_sel = ADDR_SEL_SP_P1;
                    if (mem_ready) begin
                        sp_inc    = 1'b1;
                        pc_we     = 1'b1;
                        pc_sel    = PC_SEL_MEM;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else if (to_hit) begin
                        state_nxt = S_TRAP;
                    end
                end
                S_TRAP:  state_nxt = S_TRAP;
                default: state_nxt = S_TRAP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            retired <= '0;
            to_cnt  <= '0;
            trap    <= 1'b0;
        end else begin
            state <= state_nxt;
            trap  <= trap | (state_nxt == S_TRAP);
            if (retire) retired <= retired + CNT_W'(1);
            // Wait counter restarts whenever the handshake completes or the phase changes.
            if (TIMEOUT == 0 || mem_ready || state_nxt != state) to_cnt <= '0;
            else if (mem_req) to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule
